// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state encoding and the jump opcode field layout.
// BREAKPOINT_EN adds the HALT state to the encoding.
package fetch_pkg;

    typedef enum logic [2:0] {
        ADDR_OP,
        LATCH_OP,
        ADDR_ARG,
        LATCH_ARG,
        ISSUE
`ifdef BREAKPOINT_EN
        , HALT
`endif
    } state_t;

    // Jump opcodes share the top three bits; the low bits select the condition.
    localparam logic [2:0] JMP_CLASS   = 3'b100;
    localparam int         COND_BIT    = 4;
    localparam int         FLAGSEL_BIT = 3;
    localparam int         NEG_BIT     = 2;

    localparam logic [7:0] LOAD   = 8'h00;
    localparam logic [7:0] ADD    = 8'h40;
    localparam logic [7:0] AND    = 8'h10;
    localparam logic [7:0] SUB    = 8'h60;
    localparam logic [7:0] INPUT  = 8'hA0;
    localparam logic [7:0] OUTPUT = 8'hE0;
    localparam logic [7:0] JUMP   = 8'h80;
    localparam logic [7:0] JUMPZ  = 8'h90;
    localparam logic [7:0] JUMPC  = 8'h98;
    localparam logic [7:0] JUMPNZ = 8'h94;
    localparam logic [7:0] JUMPNC = 8'h9C;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bundles program RAM, ALU flag and decoder handshake signals of the fetch unit.
// No logic, no latency.
// master = fetch unit (drives address/instruction), slave = RAM/ALU/decoder side.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] op_mem_addr;
    logic              op_mem_re;
    logic [7:0]        ip_mem_data;
    logic              ip_carry;
    logic              ip_zero;
    logic [7:0]        op_IR;
    logic [7:0]        op_arg;
    logic              op_ir_valid;
    logic              ip_ir_ready;
    logic              op_jump_taken;
    logic [ADDR_W-1:0] op_pc;

    modport master (
        output op_mem_addr, op_mem_re, op_IR, op_arg, op_ir_valid, op_jump_taken, op_pc,
        input  ip_mem_data, ip_carry, ip_zero, ip_ir_ready
    );

    modport slave (
        input  op_mem_addr, op_mem_re, op_IR, op_arg, op_ir_valid, op_jump_taken, op_pc,
        output ip_mem_data, ip_carry, ip_zero, ip_ir_ready
    );
endinterface

// File: rtl/instr_fetch_seq_jump_cond.sv
// Decides whether the current opcode is a taken jump from the ALU flags.
// Purely combinational, zero latency.
// No backpressure; output follows inputs.
module jump_cond_eval
    import fetch_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       carry,
    input  logic       zero,
    output logic       taken
);
    logic is_jmp;
    logic flag;
    logic unused_ir_low;

    assign is_jmp = (ir[7:5] == JMP_CLASS);
    assign flag   = ir[FLAGSEL_BIT] ? carry : zero;
    // Unconditional jumps ignore the flag; conditional ones compare it against the negate bit.
    assign taken  = is_jmp & (~ir[COND_BIT] | (flag ^ ir[NEG_BIT]));

    // Operand-size bits of the opcode play no part in jump resolution.
    assign unused_ir_low = ^ir[1:0];
endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches two-byte instructions from sync RAM and issues them to the decoder.
// Latency: valid rises 4 enabled edges after ADDR_OP; one instruction per 5 cycles best case.
// Backpressure: holds IR/arg with valid high until ready; ip_clock_enable=0 freezes everything.
// Optional BREAKPOINT_EN adds a PC breakpoint that parks the FSM in HALT until resumed.
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              ip_clear_n,
    input  logic              ip_clock_enable,
    instr_fetch_seq_if.master bus
`ifdef BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] ip_bp_addr,
    input  logic              ip_bp_resume,
    output logic              op_halted
`endif
);
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir_q;
    logic [7:0]        arg_q;
    logic              valid_q;
    logic              jump_q;
    logic              taken;
    logic              fetch_ok;

    jump_cond_eval u_jump_cond (
        .ir    (ir_q),
        .carry (bus.ip_carry),
        .zero  (bus.ip_zero),
        .taken (taken)
    );

`ifdef BREAKPOINT_EN
    logic bp_skip;
    logic halted_q;
    logic bp_hit;

    // A breakpoint stops the opcode read; bp_skip lets the resumed fetch through once.
    assign bp_hit    = (state == ADDR_OP) && (pc == ip_bp_addr) && !bp_skip;
    assign fetch_ok  = !bp_hit;
    assign op_halted = halted_q;
`else
    assign fetch_ok  = 1'b1;
`endif

    // Read strobe is decoded from state so the RAM sees the address in the same cycle.
    assign bus.op_mem_re     = ip_clear_n & ip_clock_enable &
                               (((state == ADDR_OP) && fetch_ok) || (state == ADDR_ARG));
    assign bus.op_mem_addr   = pc;
    assign bus.op_pc         = pc;
    assign bus.op_IR         = ir_q;
    assign bus.op_arg        = arg_q;
    assign bus.op_ir_valid   = valid_q;
    assign bus.op_jump_taken = jump_q;

    // Fetch FSM with registered outputs; all state advances only on enabled edges.
    always_ff @(posedge clock or negedge ip_clear_n) begin
        if (!ip_clear_n) begin
            state    <= ADDR_OP;
            pc       <= RESET_PC;
            ir_q     <= 8'h00;
            arg_q    <= 8'h00;
            valid_q  <= 1'b0;
            jump_q   <= 1'b0;
`ifdef BREAKPOINT_EN
            bp_skip  <= 1'b0;
            halted_q <= 1'b0;
`endif
        end else if (ip_clock_enable) begin
            jump_q <= 1'b0;
            case (state)
                ADDR_OP: begin
`ifdef BREAKPOINT_EN
                    if (bp_hit) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state    <= LATCH_OP;
                        bp_skip  <= 1'b0;
                    end
`else
                    state <= LATCH_OP;
`endif
                end
                LATCH_OP: begin
                    ir_q  <= bus.ip_mem_data;
                    pc    <= pc + ADDR_W'(1);
                    state <= ADDR_ARG;
                end
                ADDR_ARG: begin
                    state <= LATCH_ARG;
                end
                LATCH_ARG: begin
                    arg_q   <= bus.ip_mem_data;
                    pc      <= pc + ADDR_W'(1);
                    valid_q <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (bus.ip_ir_ready) begin
                        valid_q <= 1'b0;
                        state   <= ADDR_OP;
                        if (taken) begin
                            pc     <= ADDR_W'(arg_q);
                            jump_q <= 1'b1;
                        end
                    end
                end
`ifdef BREAKPOINT_EN
                HALT: begin
                    if (ip_bp_resume) begin
                        halted_q <= 1'b0;
                        bp_skip  <= 1'b1;
                        state    <= ADDR_OP;
                    end
                end
`endif
                default: begin
                    state <= ADDR_OP;
                end
            endcase
        end
    end
endmodule
